// File: rtl/demux14_tdm.sv
// demux14_tdm: receive-end deserializer for a 4:1 time-division link.
//   Counts slots, steers each serial sample back to its lane and presents the
//   rebuilt 4-lane word with a one-cycle valid strobe. An alignment loss
//   (missing or early frame marker) raises a one-cycle error pulse and the
//   block re-aligns on the next frame marker.
// Ports:
//   clk_i         rising-edge clock
//   rst_i         asynchronous, active-high reset
//   en_i          sample strobe; low holds all state and clears the pulses
//   frame_i       frame marker, high with the lane-0 sample only
//   din_i         serial lane sample
//   dout_o        rebuilt word, lane k in dout_o[k*WIDTH +: WIDTH]
//   dout_valid_o  one-cycle pulse when dout_o updates
//   slot_o        index of the next expected lane
//   sync_err_o    one-cycle pulse on an alignment error
module demux14_tdm #(
    parameter int unsigned WIDTH = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic               frame_i,
    input  logic [WIDTH-1:0]   din_i,
    output logic [4*WIDTH-1:0] dout_o,
    output logic               dout_valid_o,
    output logic [1:0]         slot_o,
    output logic               sync_err_o
);

    typedef enum logic [0:0] {StHunt, StRun} state_e;

    state_e                  state_q, state_d;
    logic [1:0]              slot_q, slot_d;
    logic [2:0][WIDTH-1:0]   shadow_q, shadow_d;
    logic [4*WIDTH-1:0]      dout_q, dout_d;
    logic                    dout_valid_q, dout_valid_d;
    logic                    sync_err_q, sync_err_d;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StHunt;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: only a missing marker at slot 0 drops back to hunting
    always_comb begin
        state_d = state_q;
        if (en_i) begin
            unique case (state_q)
                StHunt: if (frame_i) state_d = StRun;
                StRun:  if (!frame_i && slot_q == 2'd0) state_d = StHunt;
                default: state_d = StHunt;
            endcase
        end
    end

    // Output / datapath logic
    always_comb begin
        slot_d       = slot_q;
        shadow_d     = shadow_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        sync_err_d   = 1'b0;
        if (en_i) begin
            unique case (state_q)
                StHunt: begin
                    if (frame_i) begin
                        shadow_d[0] = din_i;
                        slot_d      = 2'd1;
                    end
                end
                StRun: begin
                    if (frame_i) begin
                        // A marker anywhere but slot 0 abandons the partial frame
                        sync_err_d  = (slot_q != 2'd0);
                        shadow_d[0] = din_i;
                        slot_d      = 2'd1;
                    end else if (slot_q == 2'd0) begin
                        sync_err_d = 1'b1;
                        slot_d     = 2'd0;
                    end else if (slot_q == 2'd3) begin
                        dout_d       = {din_i, shadow_q[2], shadow_q[1], shadow_q[0]};
                        dout_valid_d = 1'b1;
                        slot_d       = 2'd0;
                    end else begin
                        if (slot_q == 2'd1) begin
                            shadow_d[1] = din_i;
                        end else begin
                            shadow_d[2] = din_i;
                        end
                        slot_d = slot_q + 2'd1;
                    end
                end
                default: slot_d = 2'd0;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_q       <= 2'd0;
            shadow_q     <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            shadow_q     <= shadow_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign dout_o       = dout_q;
    assign dout_valid_o = dout_valid_q;
    assign slot_o       = slot_q;
    assign sync_err_o   = sync_err_q;

endmodule
